exp1: RTL and testbench
=======================

EXP1 -- requirements
Module: exp1

Interface
REQ-001 Parameter TRUTH_TABLE, default 16'hFE00, is the 16-entry output lookup; bit i gives S for index i = {H,O,R,N} (H is the MSB).
REQ-002 Parameter FILTER_LEN, default 3, range 1..15, is the number of consecutive stable samples required before S may change (filter build only).
REQ-003 Port clk, input, 1 bit, is the single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port H, input, 1 bit, is index bit 3.
REQ-006 Port O, input, 1 bit, is index bit 2.
REQ-007 Port R, input, 1 bit, is index bit 1.
REQ-008 Port N, input, 1 bit, is index bit 0.
REQ-009 Port S, output, 1 bit, is the registered result of the lookup.
REQ-010 Port rise_count, output, 8 bits, is a saturating count of S rising transitions.

Function
REQ-011 Index idx SHALL be {H,O,R,N}, sampled every rising clk edge; inputs are assumed synchronous to clk.
REQ-012 Without the filter, S SHALL equal TRUTH_TABLE[idx] as sampled at the previous edge (1-cycle latency).
REQ-013 With the default table, S SHALL be 1 exactly when H=1 and at least one of O, R, N is 1 (indices 9..15).
REQ-014 rise_count SHALL increment by 1 in the cycle S changes 0->1, SHALL saturate at 255, and SHALL never wrap.
REQ-015 An S 1->0 transition SHALL leave rise_count unchanged.
REQ-016 Every input change, including all 16 index values in any order and multi-bit simultaneous changes, SHALL be handled as a single new idx value.

Reset
REQ-017 While rst=1 at a rising edge: S<=0, rise_count<=0, and the filter sample register and stable counter <=0.
REQ-018 The first evaluation after reset release SHALL use idx sampled at the first edge with rst=0.
REQ-019 An asserted rst SHALL override any pending filter qualification or counter increment in the same cycle.

Configuration
REQ-020 Macro EXP1_FILTER_EN, when defined, SHALL compile in the stability filter: idx_q is registered every edge, and a stable counter resets to 0 when idx != idx_q, otherwise increments and saturates at FILTER_LEN.
REQ-021 With EXP1_FILTER_EN defined, S SHALL load TRUTH_TABLE[idx_q] only when the stable counter equals FILTER_LEN, and SHALL otherwise hold its value; an input toggling faster than FILTER_LEN cycles SHALL never change S.
REQ-022 Without EXP1_FILTER_EN, the filter logic SHALL be absent, FILTER_LEN SHALL be ignored, and REQ-012 SHALL apply.

Structure
REQ-023 Package exp1_pkg SHALL hold DEFAULT_TRUTH_TABLE (16'hFE00), the index width (4), and the rise_count width (8).
REQ-024 Sub-module exp1_stab_filter SHALL implement the filter (idx in, qualified idx and strobe out) and SHALL be instantiated only under EXP1_FILTER_EN.

Verification
REQ-025 Reset, then step {H,O,N,R} from 0 to 15 with one value per 10 cycles (no filter): S=0 for indices 0..8 and S=1 for 9..15, each one cycle after the sample.
REQ-026 Set idx=4'b1000, then 4'b1001, then 4'b1000, repeated 300 times (no filter): rise_count reaches 255 and stays at 255.
REQ-027 With the filter and FILTER_LEN=3, toggle N every 2 cycles while H=1 and O=R=0: S holds at 0 throughout.
REQ-028 With the filter and FILTER_LEN=3, step idx 0->9 and hold: S rises exactly when the stable counter reaches 3, then stays 1.
REQ-029 Assert rst for one cycle while S=1 and rise_count=5: the next cycle shows S=0 and rise_count=0.
REQ-030 Use TRUTH_TABLE=16'h0001 and apply idx=0, then idx=1: S=1, then S=0, and rise_count=1.

Source files
------------

// File: rtl/exp1_pkg.sv
// Shared constants for the exp1 lookup block.
// Widths and the default truth table live here.
package exp1_pkg;

    localparam logic [15:0] DEFAULT_TRUTH_TABLE = 16'hFE00;
    localparam int IDX_W = 4;
    localparam int RISE_W = 8;
    localparam int CNT_W = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [RISE_W-1:0] rise_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/exp1_if.sv
// Signal bundle around exp1: four index inputs, S and rise_count.
// master drives the index, slave is the lookup block side.
interface exp1_if;
    import exp1_pkg::*;

    logic  H;
    logic  O;
    logic  R;
    logic  N;
    logic  S;
    rise_t rise_count;

    modport master (
        output H, O, R, N,
        input  S, rise_count
    );

    modport slave (
        input  H, O, R, N,
        output S, rise_count
    );

endinterface

// File: rtl/exp1_stab_filter.sv
// Stability filter: strobes once idx has held for FILTER_LEN edges.
// qual_idx is the registered sample that the strobe qualifies.
module exp1_stab_filter
    import exp1_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  idx_t idx,
    output idx_t qual_idx,
    output logic strobe
);

    localparam cnt_t LEN = cnt_t'(FILTER_LEN);

    idx_t idx_q;
    idx_t idx_d;
    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        idx_d = idx;
        cnt_d = cnt_q;
        if (idx != idx_q) begin
            cnt_d = '0;
        end else if (cnt_q != LEN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign qual_idx = idx_q;
    assign strobe   = (cnt_q == LEN);

endmodule

// File: rtl/exp1.sv
// Registered 16-entry lookup of {H,O,R,N} with a saturating rise counter.
// Define EXP1_FILTER_EN to gate S updates through the stability filter.
module exp1
    import exp1_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int          FILTER_LEN  = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  H,
    input  logic  O,
    input  logic  R,
    input  logic  N,
    output logic  S,
    output rise_t rise_count
);

    idx_t  idx;
    logic  s_q;
    logic  s_d;
    rise_t rise_q;
    rise_t rise_d;

    assign idx = {H, O, R, N};

`ifdef EXP1_FILTER_EN
    idx_t qual_idx;
    logic strobe;

    exp1_stab_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filt (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .qual_idx (qual_idx),
        .strobe   (strobe)
    );

    always_comb begin
        s_d = s_q;
        if (strobe) begin
            s_d = TRUTH_TABLE[qual_idx];
        end
    end
`else
    logic [3:0] unused_flen;
    assign unused_flen = 4'(FILTER_LEN);

    always_comb begin
        s_d = TRUTH_TABLE[idx];
    end
`endif

    // Count only 0->1 edges of S; hold at all-ones rather than wrap.
    always_comb begin
        rise_d = rise_q;
        if (s_d && !s_q && (rise_q != '1)) begin
            rise_d = rise_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= 1'b0;
            rise_q <= '0;
        end else begin
            s_q    <= s_d;
            rise_q <= rise_d;
        end
    end

    assign S          = s_q;
    assign rise_count = rise_q;

endmodule

// File: tb/tb_exp1.sv
// Scoreboard bench for exp1: default table DUT plus a 16'h0001 table DUT.
// Expected values come from the lookup rules, not from the tables.
module tb_exp1;

    localparam int FLEN = 3;

    typedef struct packed {
        logic       s1;
        logic [7:0] r1;
        logic       s2;
        logic [7:0] r2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp1_if bus1 ();
    exp1_if bus2 ();

    assign bus2.H = bus1.H;
    assign bus2.O = bus1.O;
    assign bus2.R = bus1.R;
    assign bus2.N = bus1.N;

    exp1 #(
        .TRUTH_TABLE (16'hFE00),
        .FILTER_LEN  (FLEN)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .H          (bus1.H),
        .O          (bus1.O),
        .R          (bus1.R),
        .N          (bus1.N),
        .S          (bus1.S),
        .rise_count (bus1.rise_count)
    );

    exp1 #(
        .TRUTH_TABLE (16'h0001),
        .FILTER_LEN  (FLEN)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .H          (bus2.H),
        .O          (bus2.O),
        .R          (bus2.R),
        .N          (bus2.N),
        .S          (bus2.S),
        .rise_count (bus2.rise_count)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic ms1 = 1'b0;
    logic ms2 = 1'b0;
    int   mr1 = 0;
    int   mr2 = 0;
`ifdef EXP1_FILTER_EN
    logic [3:0] hist[$];
`endif

    task automatic drive(input logic [3:0] idx, input logic r);
        logic       ld;
        logic [3:0] li;
        logic       n1;
        logic       n2;
        exp_t       e;
        @(negedge clk);
        bus1.H = idx[3];
        bus1.O = idx[2];
        bus1.R = idx[1];
        bus1.N = idx[0];
        rst    = r;
        if (r) begin
            ms1 = 1'b0;
            ms2 = 1'b0;
            mr1 = 0;
            mr2 = 0;
`ifdef EXP1_FILTER_EN
            hist.delete();
            hist.push_back(4'd0);
`endif
        end else begin
`ifdef EXP1_FILTER_EN
            // S may load only if the previous FLEN+1 samples all agree.
            ld = (hist.size() >= FLEN + 1);
            for (int i = 1; i <= FLEN; i++) begin
                if (ld && hist[hist.size()-1-i] != hist[hist.size()-1])
                    ld = 1'b0;
            end
            li = hist[hist.size()-1];
            hist.push_back(idx);
            if (hist.size() > 32) void'(hist.pop_front());
`else
            ld = 1'b1;
            li = idx;
`endif
            n1 = ld ? (li[3] && (li[2:0] != 3'd0)) : ms1;
            n2 = ld ? (li == 4'd0) : ms2;
            if (n1 && !ms1 && mr1 < 255) mr1++;
            if (n2 && !ms2 && mr2 < 255) mr2++;
            ms1 = n1;
            ms2 = n2;
        end
        e.s1 = ms1;
        e.r1 = 8'(mr1);
        e.s2 = ms2;
        e.r2 = 8'(mr2);
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("s_tt_fe00", int'(bus1.S), int'(e.s1));
            chk("rise_tt_fe00", int'(bus1.rise_count), int'(e.r1));
            chk("s_tt_0001", int'(bus2.S), int'(e.s2));
            chk("rise_tt_0001", int'(bus2.rise_count), int'(e.r2));
        end
    end

    initial begin
        logic [3:0] v;
        bus1.H = 1'b0;
        bus1.O = 1'b0;
        bus1.R = 1'b0;
        bus1.N = 1'b0;
        repeat (2) drive(4'd0, 1'b1);

        // Sweep with the vector ordered {H,O,N,R}.
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            repeat (10) drive({v[3], v[2], v[0], v[1]}, 1'b0);
        end

        drive(4'd0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            drive(4'b1000, 1'b0);
            drive(4'b1001, 1'b0);
            drive(4'b1000, 1'b0);
        end
        repeat (5) drive(4'b1000, 1'b0);

        drive(4'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            repeat (5) drive(4'b1000, 1'b0);
            repeat (5) drive(4'b1001, 1'b0);
        end
        drive(4'b1001, 1'b1);
        repeat (3) drive(4'b1001, 1'b0);

        drive(4'd0, 1'b1);
        repeat (6) drive(4'd0, 1'b0);
        repeat (6) drive(4'd1, 1'b0);

        drive(4'd0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            repeat (2) drive(4'b1000, 1'b0);
            repeat (2) drive(4'b1001, 1'b0);
        end
        repeat (10) drive(4'd0, 1'b0);
        repeat (10) drive(4'd9, 1'b0);

        for (int k = 0; k < 150; k++) begin
            v = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 6))
                drive(v, ($urandom_range(0, 59) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
